// File: rtl/pc_gen.sv
// pc_gen: program-counter register with next-PC selection for the RISC-V core.
// Handles sequential fetch, PC-relative and register-indirect redirects, and
// APB-induced stalls. A redirect seen during a stall is captured once and
// applied on release. Misaligned targets are rejected with a sticky flag.
//
// Ports:
//   i_clk               system clock (rising edge)
//   i_rst               synchronous active-high reset
//   i_stop              stall request from the APB bridge (1 = hold PC)
//   i_redirect_valid    current instruction redirects control flow
//   i_redirect_sel      0 = pc + imm_ext, 1 = (rs1_val + imm_ext) & ~1
//   i_imm_ext           sign-extended immediate
//   i_rs1_val           rs1 operand for jalr
//   o_pc                registered current PC
//   o_pc_plus           pc + INST_BYTES (combinational link value)
//   o_pc_target         combinational redirect target
//   o_redirect_pending  a captured redirect awaits stall release
//   o_misalign          sticky misaligned-target flag
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INST_BYTES   = 4,
  parameter bit              ALIGN_CHECK  = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stop,
  input  logic            i_redirect_valid,
  input  logic            i_redirect_sel,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic [XLEN-1:0] i_rs1_val,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_redirect_pending,
  output logic            o_misalign
);

  localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_target;
  logic            r_pending;
  logic            r_misalign;

  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_rel_target;
  logic [XLEN-1:0] w_ind_sum;
  logic [XLEN-1:0] w_target;

  // Target arithmetic wraps modulo 2^XLEN; indirect target drops bit 0.
  assign w_pc_plus    = r_pc + INC_VAL;
  assign w_rel_target = r_pc + i_imm_ext;
  assign w_ind_sum    = i_rs1_val + i_imm_ext;
  assign w_target     = i_redirect_sel ? {w_ind_sum[XLEN-1:1], 1'b0} : w_rel_target;

  function automatic logic f_misaligned(input logic [XLEN-1:0] t);
    return ALIGN_CHECK && ((t & ALIGN_MASK) != '0);
  endfunction

  // PC register, stall FSM, capture register and sticky flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_VECTOR;
      r_pend_target <= '0;
      r_pending     <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        RUN, HOLD: begin
          if (!i_stop) begin
            // Zero-penalty resume: the release edge already advances pc.
            if (i_redirect_valid) begin
              if (f_misaligned(w_target)) r_misalign <= 1'b1;
              else                        r_pc       <= w_target;
            end else begin
              r_pc <= w_pc_plus;
            end
            r_state <= RUN;
          end else if (i_redirect_valid) begin
            r_pend_target <= w_target;
            r_pending     <= 1'b1;
            r_state       <= HOLD_PEND;
          end else begin
            r_state <= HOLD;
          end
        end
        HOLD_PEND: begin
          // First capture wins; live redirect inputs are ignored here.
          if (!i_stop) begin
            if (f_misaligned(r_pend_target)) r_misalign <= 1'b1;
            else                             r_pc       <= r_pend_target;
            r_pending <= 1'b0;
            r_state   <= RUN;
          end
        end
        default: begin
          r_pending <= 1'b0;
          r_state   <= RUN;
        end
      endcase
    end
  end

  assign o_pc               = r_pc;
  assign o_pc_plus          = w_pc_plus;
  assign o_pc_target        = w_target;
  assign o_redirect_pending = r_pending;
  assign o_misalign         = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen with hand-computed values.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stop;
  logic        redirect_valid;
  logic        redirect_sel;
  logic [31:0] imm_ext;
  logic [31:0] rs1_val;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] pc_target;
  logic        redirect_pending;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .INST_BYTES(4), .ALIGN_CHECK(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_stop(stop),
    .i_redirect_valid(redirect_valid),
    .i_redirect_sel(redirect_sel),
    .i_imm_ext(imm_ext),
    .i_rs1_val(rs1_val),
    .o_pc(pc),
    .o_pc_plus(pc_plus),
    .o_pc_target(pc_target),
    .o_redirect_pending(redirect_pending),
    .o_misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load an aligned pc through an indirect redirect (rs1 = addr, imm = 0).
  task automatic load_pc(input logic [31:0] addr);
    stop = 1'b0; redirect_valid = 1'b1; redirect_sel = 1'b1;
    rs1_val = addr; imm_ext = 32'h0;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0;
    imm_ext = '0; rs1_val = '0;

    // Reset then sequential fetch
    step(); step();
    rst = 1'b0;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pend", 32'(redirect_pending), 32'h0);
    check_eq("rst_mis", 32'(misalign), 32'h0);
    step(); check_eq("seq_4", pc, 32'h4);
    step(); check_eq("seq_8", pc, 32'h8);
    step(); check_eq("seq_c", pc, 32'hC);
    step(); check_eq("seq_10", pc, 32'h10);
    check_eq("seq_mis", 32'(misalign), 32'h0);

    // PC-relative branch with negative offset
    load_pc(32'h100);
    check_eq("ld_100", pc, 32'h100);
    redirect_valid = 1'b1; redirect_sel = 1'b0; imm_ext = 32'hFFFF_FFF0;
    #1 check_eq("br_target", pc_target, 32'hF0);
    step(); redirect_valid = 1'b0;
    check_eq("br_pc", pc, 32'hF0);

    // jalr clears bit 0; link value during the redirect cycle
    load_pc(32'h20);
    redirect_valid = 1'b1; redirect_sel = 1'b1; rs1_val = 32'h1001; imm_ext = 32'h4;
    #1 check_eq("jalr_link", pc_plus, 32'h24);
    check_eq("jalr_target", pc_target, 32'h1004);
    step(); redirect_valid = 1'b0;
    check_eq("jalr_pc", pc, 32'h1004);

    // Stall with capture: first target wins, later operand change ignored
    load_pc(32'h40);
    stop = 1'b1; redirect_valid = 1'b1; redirect_sel = 1'b0; imm_ext = 32'h40;
    #1 check_eq("st_target", pc_target, 32'h80);
    step(); redirect_valid = 1'b0;
    check_eq("st_c1_pc", pc, 32'h40);
    check_eq("st_c1_pend", 32'(redirect_pending), 32'h1);
    step();
    check_eq("st_c2_pend", 32'(redirect_pending), 32'h1);
    redirect_valid = 1'b1; imm_ext = 32'h1C0;
    #1 check_eq("st_c3_target", pc_target, 32'h200);
    step(); redirect_valid = 1'b0;
    check_eq("st_c3_pc", pc, 32'h40);
    step(); step();
    check_eq("st_c5_pc", pc, 32'h40);
    check_eq("st_c5_pend", 32'(redirect_pending), 32'h1);
    stop = 1'b0; redirect_valid = 1'b1;  // ignored on release
    step(); redirect_valid = 1'b0;
    check_eq("st_rel_pc", pc, 32'h80);
    check_eq("st_rel_pend", 32'(redirect_pending), 32'h0);
    step(); check_eq("st_after", pc, 32'h84);

    // Plain stall without redirect, zero-penalty resume
    stop = 1'b1;
    step(); check_eq("hold_pc", pc, 32'h84);
    check_eq("hold_pend", 32'(redirect_pending), 32'h0);
    stop = 1'b0;
    step(); check_eq("hold_rel", pc, 32'h88);

    // Wrap to zero, then misaligned branch
    load_pc(32'hFFFF_FFFC);
    check_eq("ld_top", pc, 32'hFFFF_FFFC);
    step(); check_eq("wrap_pc", pc, 32'h0);
    redirect_valid = 1'b1; redirect_sel = 1'b0; imm_ext = 32'h2;
    step(); redirect_valid = 1'b0;
    check_eq("mis_pc", pc, 32'h0);
    check_eq("mis_flag", 32'(misalign), 32'h1);
    step(); check_eq("mis_run_pc", pc, 32'h4);
    check_eq("mis_sticky", 32'(misalign), 32'h1);

    // Reset while a captured redirect is pending
    stop = 1'b1; redirect_valid = 1'b1; redirect_sel = 1'b1;
    rs1_val = 32'h300; imm_ext = 32'h0;
    step(); redirect_valid = 1'b0;
    check_eq("rp_pend", 32'(redirect_pending), 32'h1);
    check_eq("rp_pc", pc, 32'h4);
    rst = 1'b1;
    step(); rst = 1'b0;
    check_eq("rp_rst_pc", pc, 32'h0);
    check_eq("rp_rst_pend", 32'(redirect_pending), 32'h0);
    check_eq("rp_rst_mis", 32'(misalign), 32'h0);
    step(); check_eq("rp_hold_pc", pc, 32'h0);
    check_eq("rp_hold_pend", 32'(redirect_pending), 32'h0);
    stop = 1'b0;
    step(); check_eq("rp_no_apply", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the SoC RISC-V core. It generalises the stall-aware branch-target adder into a full PC register and next-PC selection. It handles sequential fetch, PC-relative and register-indirect redirects, and APB-induced stalls. A redirect seen during a stall is captured once and applied on release, so operand changes during a long peripheral wait cannot corrupt the target. It sits between the control unit, the APB master/bridge stall output and the instruction memory address port.

## Interface
- XLEN, 32: datapath/PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- INST_BYTES, 4: sequential increment; must be a power of two.
- ALIGN_CHECK, 1: 1 enables the misaligned-target trap; 0 disables it.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stop  in  1  stall request from the APB bridge; 1 = hold PC.
- redirect_valid  in  1  current instruction redirects control flow (taken branch, jal, jalr).
- redirect_sel  in  1  0 = PC-relative (pc + imm_ext); 1 = indirect ((rs1_val + imm_ext) with bit 0 cleared).
- imm_ext  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  rs1 operand for jalr.
- pc  out  XLEN  registered current PC (instruction address).
- pc_plus  out  XLEN  pc + INST_BYTES (link value), combinational.
- pc_target  out  XLEN  combinational computed redirect target (as selected by redirect_sel).
- redirect_pending  out  1  a captured redirect awaits stall release.
- misalign  out  1  sticky: a misaligned target was rejected.

## Operation
- State machine: RUN, HOLD, HOLD_PEND; 2-bit encoding; reset state RUN. Internal register pend_target (XLEN).
- Target arithmetic is modulo 2^XLEN; carries out are discarded, with no saturation. Indirect target has bit 0 forced to 0 before the alignment check.
- Misaligned means target mod INST_BYTES != 0, and ALIGN_CHECK = 1.
- RUN, stop=0: if redirect_valid and target aligned, pc <= pc_target. If redirect_valid and misaligned, pc holds and misalign <= 1. Otherwise pc <= pc + INST_BYTES. Stay RUN.
- RUN, stop=1: pc holds. If redirect_valid, pend_target <= pc_target and go to HOLD_PEND. Otherwise go to HOLD.
- HOLD, stop=1: pc holds. A redirect_valid captures pend_target and goes to HOLD_PEND.
- HOLD, stop=0: behaves exactly as RUN with stop=0, then goes to RUN.
- HOLD_PEND, stop=1: pc holds. Later redirect_valid/operand changes are ignored; the first capture wins.
- HOLD_PEND, stop=0: apply pend_target with the same alignment rule as RUN. Inputs redirect_valid, imm_ext and rs1_val are ignored this cycle. Go to RUN.
- redirect_pending = 1 iff state is HOLD_PEND.
- misalign stays set until rst; the core keeps running from the held PC.
- rst overrides everything, including mid-stall or a pending redirect. On rst: pc = RESET_VECTOR, state RUN, pend_target = 0, misalign = 0, redirect_pending = 0.

## Timing
- pc updates one cycle after the decision cycle; there is no further latency.
- pc_plus and pc_target are purely combinational from pc, imm_ext, rs1_val and redirect_sel.
- The stall-to-resume penalty is zero: the edge on which stop is sampled 0 advances pc.
- Minimum stall is 1 cycle. Captured-redirect application latency is exactly 1 cycle after stop falls.
- Reset is sampled on clk edge only. The first post-reset fetch address is RESET_VECTOR in the cycle after rst falls.

## Test plan
- Reset/sequential: rst for 2 cycles, then 4 idle cycles. Required: pc = 0x0, then 0x4, 0x8, 0xC, 0x10; misalign = 0.
- Branch: pc = 0x100, redirect_valid=1, sel=0, imm_ext=0xFFFFFFF0. Required: next pc = 0xF0.
- jalr with bit 0: pc = 0x20, sel=1, rs1_val=0x1001, imm_ext=0x4. Required: next pc = 0x1004; pc_plus = 0x24 during the redirect cycle.
- Stall with capture: pc=0x40, stop=1 for 5 cycles. Cycle 1: redirect to 0x80. Cycle 3: imm_ext changes so pc_target = 0x200. Required: pc holds 0x40 and redirect_pending=1 from cycle 2. On stop=0, the next pc = 0x80 and pending clears.
- Misalign/wrap: pc=0xFFFFFFFC with no redirect. Required: next pc = 0x0. Then a branch with imm_ext=0x2. Required: pc holds 0x0, misalign=1, and misalign stays 1 until rst.
- Reset mid-pending: enter HOLD_PEND, then assert rst while stop=1. Required: pc = RESET_VECTOR, redirect_pending=0, and the captured target is never applied.
